// File: rtl/pusch_crc_pkg.sv
// Shared types and constants for the PUSCH CRC attachment path: CRC width,
// controller state encoding and the error codes reported to the host.
package pusch_crc_pkg;

    localparam int CRC_W = 16;
    localparam int IDX_W = $clog2(CRC_W);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEED     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_WAIT_CRC = 3'd5,
        ST_APPEND   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_GAP  = 2'b10,
        ERR_TMO  = 2'b11
    } err_code_e;

endpackage

// File: rtl/crc_attach_ctrl_if.sv
// Signal bundle between the TB source, the segmentation stage, the CRC engine
// and crc_attach_ctrl; slave is the controller's view, master the environment's.
interface crc_attach_ctrl_if #(
    parameter int LEN_W = 16
);
    import pusch_crc_pkg::*;

    logic             start;
    logic [LEN_W-1:0] tb_len;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             crc_rst_n;
    logic             crc_data;
    logic             crc_active;
    logic [CRC_W-1:0] crc_word;
    logic             crc_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    modport slave (
        input  start, tb_len, in_bit, in_valid, out_ready, crc_word, crc_valid,
        output in_ready, out_bit, out_valid, out_last, crc_rst_n, crc_data,
               crc_active, busy, done, err, err_code
    );

    modport master (
        output start, tb_len, in_bit, in_valid, out_ready, crc_word, crc_valid,
        input  in_ready, out_bit, out_valid, out_last, crc_rst_n, crc_data,
               crc_active, busy, done, err, err_code
    );

endinterface

// File: rtl/crc_append_serializer.sv
// Holds the captured CRC word and presents it one bit per accepted transfer,
// bit 0 first, flagging the final bit.
module crc_append_serializer
    import pusch_crc_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [CRC_W-1:0] word_i,
    input  logic             shift_i,
    output logic             bit_o,
    output logic             last_o
);

    logic [CRC_W-1:0] sr_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_q <= '0;
        end else if (load_i) begin
            idx_q <= '0;
        end else if (shift_i) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // Shift register carries data only; the index decides what is valid.
    always_ff @(posedge CLK) begin
        if (load_i) begin
            sr_q <= word_i;
        end else if (shift_i) begin
            sr_q <= {1'b0, sr_q[CRC_W-1:1]};
        end
    end

    assign bit_o  = sr_q[0];
    assign last_o = (idx_q == IDX_W'(CRC_W - 1));

endmodule

// File: rtl/crc_attach_ctrl.sv
// Sequences the serial CRC-16 engine for PUSCH transport-block CRC attachment:
// payload pass-through, engine feed and reseed, CRC wait with timeout, CRC append.
module crc_attach_ctrl
    import pusch_crc_pkg::*;
#(
    parameter int LEN_W       = 16,
    parameter int CRC_TIMEOUT = 32
) (
    input logic              CLK,
    input logic              RST,
    crc_attach_ctrl_if.slave bus_io
);

    localparam int TMO_W = $clog2(CRC_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             crc_rst_n_q, crc_rst_n_d;
    logic             crc_data_q, crc_data_d;
    logic             crc_active_q, crc_active_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic pass, xfer_in, is_append;
    logic ser_load, ser_shift, ser_bit, ser_last;

    crc_append_serializer u_ser (
        .CLK     (CLK),
        .RST     (RST),
        .load_i  (ser_load),
        .word_i  (bus_io.crc_word),
        .shift_i (ser_shift),
        .bit_o   (ser_bit),
        .last_o  (ser_last)
    );

    assign pass      = (state_q == ST_ARMED) || (state_q == ST_PAYLOAD);
    assign is_append = (state_q == ST_APPEND);
    assign xfer_in   = pass && bus_io.in_valid && bus_io.out_ready;

    // Payload path is purely combinational so the block adds no latency.
    assign bus_io.in_ready   = pass && bus_io.out_ready;
    assign bus_io.out_valid  = pass ? bus_io.in_valid : is_append;
    assign bus_io.out_bit    = pass ? bus_io.in_bit : (is_append && ser_bit);
    assign bus_io.out_last   = is_append && ser_last;
    assign bus_io.busy       = (state_q != ST_IDLE);
    assign bus_io.crc_rst_n  = crc_rst_n_q;
    assign bus_io.crc_data   = crc_data_q;
    assign bus_io.crc_active = crc_active_q;
    assign bus_io.done       = done_q;
    assign bus_io.err        = err_q;
    assign bus_io.err_code   = err_code_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            crc_rst_n_q  <= 1'b0;
            crc_data_q   <= 1'b0;
            crc_active_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            crc_rst_n_q  <= crc_rst_n_d;
            crc_data_q   <= crc_data_d;
            crc_active_q <= crc_active_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        crc_rst_n_d  = 1'b1;
        crc_data_d   = crc_data_q;
        crc_active_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;

        if (xfer_in) begin
            crc_active_d = 1'b1;
            crc_data_d   = bus_io.in_bit;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus_io.start) begin
                    if (bus_io.tb_len == '0) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        len_d   = bus_io.tb_len;
                        cnt_d   = '0;
                        state_d = ST_SEED;
                    end
                end
            end
            ST_SEED: state_d = ST_ARMED;
            ST_ARMED, ST_PAYLOAD: begin
                if (xfer_in) begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q + LEN_W'(1) == len_q) ? ST_DRAIN : ST_PAYLOAD;
                end else if (state_q == ST_PAYLOAD) begin
                    // A stalled bit lets the engine begin unloading a partial CRC.
                    err_d       = 1'b1;
                    err_code_d  = ERR_GAP;
                    crc_rst_n_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                tmo_d   = '0;
                state_d = ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                tmo_d = tmo_q + TMO_W'(1);
                // The entry cycle (count 0) may still see a stale result.
                if (bus_io.crc_valid && (tmo_q != '0)) begin
                    ser_load = 1'b1;
                    state_d  = ST_APPEND;
                end else if (tmo_q + TMO_W'(1) >= TMO_W'(CRC_TIMEOUT)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = ST_IDLE;
                end
            end
            ST_APPEND: begin
                if (bus_io.out_ready) begin
                    ser_shift = 1'b1;
                    if (ser_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_SEED) begin
            crc_rst_n_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_crc_attach_ctrl.sv
// Scoreboard bench for crc_attach_ctrl with a bit-serial CRC-16 engine model and
// a polynomial-division golden CRC.
module tb_crc_attach_ctrl;
    import pusch_crc_pkg::*;

    localparam int LEN_W = 16;
    localparam int TMO   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_attach_ctrl_if #(.LEN_W(LEN_W)) bus ();

    crc_attach_ctrl #(.LEN_W(LEN_W), .CRC_TIMEOUT(TMO)) dut (
        .CLK    (clk),
        .RST    (rst_n),
        .bus_io (bus.slave)
    );

    typedef struct { bit b; bit last; } obit_t;
    typedef struct { bit is_err; logic [1:0] code; } ev_t;

    obit_t exp_q[$];
    ev_t   ev_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Golden CRC: remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] golden_crc(input bit msg[$]);
        bit m[$];
        logic [16:0] g = 17'h11021;
        logic [15:0] r;
        m = msg;
        repeat (16) m.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++)
            if (m[i]) for (int k = 0; k < 17; k++) m[i+k] ^= g[16-k];
        for (int k = 0; k < 16; k++) r[15-k] = m[msg.size()+k];
        return r;
    endfunction

    // Engine model: bit-serial LFSR, cleared only by crc_rst_n, result eng_d cycles after ACTIVE falls.
    logic [15:0] eng_lfsr = '0;
    logic        eng_fb;
    bit          eng_seen = 0;
    int          eng_dly = 0;
    int          eng_d = 17;
    bit          eng_mute = 0;

    always @(negedge clk) begin
        bus.crc_valid = 1'b0;
        if (!bus.crc_rst_n) begin
            eng_lfsr = '0; eng_seen = 0; eng_dly = 0;
        end else if (bus.crc_active) begin
            eng_fb   = bus.crc_data ^ eng_lfsr[15];
            eng_lfsr = {eng_lfsr[14:0], 1'b0} ^ (eng_fb ? 16'h1021 : 16'h0000);
            eng_seen = 1; eng_dly = 0;
        end else if (eng_seen) begin
            eng_dly++;
            if (eng_dly == eng_d) begin
                eng_seen = 0;
                if (!eng_mute) begin bus.crc_valid = 1'b1; bus.crc_word = eng_lfsr; end
            end
        end
    end

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on every output transfer and on every done/err pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out_xfer", 1, 0);
                else begin
                    obit_t e;
                    e = exp_q.pop_front();
                    check("out_bit", bus.out_bit, e.b);
                    check("out_last", bus.out_last, e.last);
                    if (e.last) last_cyc = cyc;
                end
            end
            if (bus.done || bus.err) begin
                if (ev_q.size() == 0) check("unexpected_event", {bus.done, bus.err}, 0);
                else begin
                    ev_t v;
                    v = ev_q.pop_front();
                    check("event_is_err", bus.err, v.is_err);
                    check("event_is_done", bus.done, !v.is_err);
                    if (v.is_err) check("err_code", bus.err_code, v.code);
                    else check("done_latency", cyc - last_cyc, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 300) begin tick(); n++; end
        check("idle_reached", bus.busy, 0);
    endtask

    task automatic rand_bits(input int len, output bit q[$]);
        q.delete();
        for (int i = 0; i < len; i++) q.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic send_block(input bit bits[$], input bit toggle, input int gap_at,
                              input bit mute, input bit noise, input bit rst_mid);
        int len = bits.size();
        logic [15:0] gold;
        int n;
        bit tg = 1'b1;
        wait_idle();
        eng_mute = mute;
        bus.start = 1'b1; bus.tb_len = LEN_W'(len); bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("seed_crc_rst_n", bus.crc_rst_n, 0);
        check("seed_busy", bus.busy, 1);
        tick();
        check("armed_crc_rst_n", bus.crc_rst_n, 1);
        repeat ($urandom_range(0, 3)) begin bus.in_valid = 1'b0; tick(); end
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                bus.in_valid = 1'b0; bus.start = 1'b0;
                ev_q.push_back('{is_err: 1'b1, code: ERR_GAP});
                tick();
                @(negedge clk);
                check("gap_crc_rst_n_low", bus.crc_rst_n, 0);
                check("gap_busy", bus.busy, 0);
                @(negedge clk);
                check("gap_crc_rst_n_high", bus.crc_rst_n, 1);
                tick();
                check("gap_exp_empty", exp_q.size(), 0);
                check("gap_ev_empty", ev_q.size(), 0);
                return;
            end
            exp_q.push_back('{b: bits[i], last: 1'b0});
            bus.in_valid = 1'b1; bus.in_bit = bits[i];
            if (noise) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.tb_len = LEN_W'($urandom_range(0, 3));
            end
            tick();
        end
        bus.in_valid = 1'b0; bus.start = 1'b0;
        if (mute) begin
            ev_q.push_back('{is_err: 1'b1, code: ERR_TMO});
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.err && n < TMO + 10);
            check("timeout_cycles", n, TMO + 2);
            tick();
        end else begin
            gold = golden_crc(bits);
            for (int j = 0; j < 16; j++) exp_q.push_back('{b: gold[j], last: (j == 15)});
            if (rst_mid) begin
                n = 0;
                while (!bus.out_valid && n < 100) begin tick(); n++; end
                check("append_reached", bus.out_valid, 1);
                repeat (5) tick();
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", bus.out_valid, 0);
                check("rst_out_last", bus.out_last, 0);
                check("rst_out_bit", bus.out_bit, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_crc_rst_n", bus.crc_rst_n, 0);
                check("rst_crc_active", bus.crc_active, 0);
                check("rst_err_code", bus.err_code, 0);
                check("rst_done_err", {bus.done, bus.err}, 0);
                exp_q.delete(); ev_q.delete();
                tick();
                rst_n = 1'b1;
                @(negedge clk);
                check("rel_crc_rst_n_low", bus.crc_rst_n, 0);
                tick();
                check("rel_crc_rst_n_high", bus.crc_rst_n, 1);
                return;
            end
            ev_q.push_back('{is_err: 1'b0, code: 2'b00});
            n = 0;
            while (bus.busy && n < 200) begin
                bus.out_ready = toggle ? tg : 1'b1;
                tg = ~tg;
                tick(); n++;
            end
            check("block_finished", bus.busy, 0);
            bus.out_ready = 1'b1;
        end
        tick();
        check("exp_q_empty", exp_q.size(), 0);
        check("ev_q_empty", ev_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bits[$];
        int len, gap;
        bus.start = 1'b0; bus.tb_len = '0; bus.in_bit = 1'b0; bus.in_valid = 1'b0;
        bus.out_ready = 1'b1; bus.crc_word = '0; bus.crc_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_crc_rst_n", bus.crc_rst_n, 0);
        check("reset_crc_active", bus.crc_active, 0);
        check("reset_err_code", bus.err_code, 0);
        check("reset_done_err", {bus.done, bus.err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_crc_rst_n", bus.crc_rst_n, 1);

        // Fixed 8-bit payload 0xA5, MSB first, with and without APPEND backpressure.
        bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        eng_d = 17;
        send_block(bits, 0, -1, 0, 0, 0);
        send_block(bits, 1, -1, 0, 0, 0);
        // Gap on the 4th payload cycle.
        send_block(bits, 0, 3, 0, 0, 0);
        // Engine never answers.
        send_block(bits, 0, -1, 1, 0, 0);

        // Zero-length start: error only, never busy.
        wait_idle();
        ev_q.push_back('{is_err: 1'b1, code: ERR_LEN});
        bus.start = 1'b1; bus.tb_len = '0;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        check("len0_busy_a", bus.busy, 0);
        tick();
        check("len0_busy_b", bus.busy, 0);
        check("len0_ev_empty", ev_q.size(), 0);

        // Start requests while busy, single-bit block, reset mid-APPEND then a fresh block.
        rand_bits(8, bits);
        send_block(bits, 0, -1, 0, 1, 0);
        rand_bits(1, bits);
        send_block(bits, 1, -1, 0, 0, 0);
        rand_bits(8, bits);
        send_block(bits, 0, -1, 0, 0, 1);
        rand_bits(8, bits);
        send_block(bits, 0, -1, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            len   = $urandom_range(1, 40);
            eng_d = $urandom_range(2, 20);
            gap   = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
            rand_bits(len, bits);
            send_block(bits, 1'($urandom_range(0, 1)), gap, 0, 1, 0);
        end

        repeat (4) tick();
        check("final_exp_q_empty", exp_q.size(), 0);
        check("final_ev_q_empty", ev_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
